sobel_edge_proc: RTL and testbench
==================================

// Module: sobel_edge_proc
// PURPOSE
//  Frame-buffer-to-frame-buffer Sobel edge detector for the 80x60 gray camera path.
//  Reads 8-bit gray pixels from the capture frame buffer's read port in raster order.
//  Computes |Gx|+|Gy| with a 3x3 kernel, saturates to 8 bits and writes the result
//  to the processed frame buffer, which the VGA/display side reads.
//  One pass is started per frame by a pulse, typically the end-of-frame event.
// PARAMETERS
//  c_img_cols      80  image width in pixels
//  c_img_rows      60  image height in lines
//  c_nb_line_pxls   7  column counter width, log2(c_img_cols)+1
//  c_nb_img_pxls   13  frame-buffer address width
//  c_nb_gray        8  gray/result pixel width
// PORTS
//  clk        in   1              system clock (50 MHz)
//  rst        in   1              asynchronous reset, active-high
//  start      in   1              1-cycle pulse; begins one frame pass when idle
//  busy       out  1              high from the cycle after an accepted start until done
//  done       out  1              1-cycle pulse after the last write of a pass
//  orig_addr  out  c_nb_img_pxls  source buffer read address
//  orig_pxl   in   c_nb_gray      source pixel; valid 1 clk after orig_addr (sync RAM)
//  proc_addr  out  c_nb_img_pxls  result buffer write address
//  proc_dout  out  c_nb_gray      result pixel
//  proc_we    out  1              result buffer write enable
// BEHAVIOUR
//  - Reset: busy=0, done=0, proc_we=0, orig_addr=0, proc_addr=0, proc_dout=0.
//    All counters, window registers and pipeline valid bits are cleared.
//  - FSM IDLE -> SCAN -> FLUSH -> IDLE.
//    - IDLE: on start, clear r/c counters and go to SCAN. start is ignored outside IDLE.
//    - SCAN: virtual scan r=0..c_img_rows, c=0..c_img_cols (61x81 = 4941 steps, 1 step/clk).
//    - Steps with r<rows and c<cols read orig_addr=r*cols+c. Padding steps (r==rows or
//      c==cols) issue no meaningful read and inject pixel value 0.
//    - After step (rows,cols), go to FLUSH and wait for the 3-stage pipeline to drain.
//      Then pulse done and return to IDLE.
//  - Pipeline (one step per clk, no stalls):
//    - S0: address issue.
//    - S1: pixel arrives; window shifts left; new column = {lb2[c], lb1[c], pxl};
//      then lb2[c]<=lb1[c] and lb1[c]<=pxl.
//    - S2: register gx and gy, 11-bit signed.
//    - S3: register mag=|gx|+|gy|; proc_dout=min(mag,255); proc_we=1.
//    - Latency from S0 to proc_we is exactly 3 clks.
//  - Line buffers lb1/lb2 hold c_img_cols+1 entries, indexed by c including the padding column.
//  - A write happens only for steps with r>=1 and c>=1. It targets the window centre:
//    proc_addr=(r-1)*cols+(c-1). This yields exactly 4800 writes per pass, covering every address once.
//  - Kernels, with p[row][col] over the window and row 0 at the top:
//    gx=(p02+2p12+p22)-(p00+2p10+p20), gy=(p20+2p21+p22)-(p00+2p01+p02).
//  - Border centres (row 0, row rows-1, col 0, col cols-1) are written as 0,
//    independent of the window contents.
//  - The window is not cleared between lines. Stale window data only affects border
//    centres, which are forced to 0.
//  - done and start in the same cycle: done completes and the start is accepted
//    (the FSM is IDLE in that cycle).
//  - Reset mid-pass: immediate abort to IDLE. No done pulse, no further writes.
//    The next start runs a full, clean pass.
// STRUCTURE
//  - Shared include: c_img_cols, c_img_rows, c_nb_img_pxls, c_nb_line_pxls, c_nb_gray.
//    The capture, this block and the VGA reader all use it.
//  - Sub-module sobel_kernel: 3x3 window in, S2/S3 registered gx/gy/|.|/saturate out.
//    The FSM, counters and line buffers stay in the top level.
// TESTING
//  1 Flat image, all pixels 0x80 -> all 4800 results 0x00; done exactly once.
//  2 Vertical step (cols 0..39 = 0, cols 40..79 = 255) -> interior cols 39 and 40 = 255
//    (gx=1020, saturated); all other results 0.
//  3 Horizontal ramp, pixel = c -> interior results 8 (gx=8, gy=0); border rows/cols 0.
//  4 Handshake: start, then a 2nd start 100 clks later -> 2nd ignored.
//    Writes: first write is proc_addr=0 and last is 4799; 4800 total writes,
//    each address written once. done follows the last write by 1 clk.
//  5 Reset asserted at step ~2000 -> outputs at reset values, no done pulse.
//    A new start then reproduces test 1 results bit-exactly.
//  6 RAM latency check: random image -> results match a software Sobel reference model
//    (|gx|+|gy|, saturated to 255, borders 0).

Source files
------------

// File: rtl/sobel_edge_proc_pkg.sv
// Shared image geometry, pixel/address types and FSM state for the Sobel edge processor.
package sobel_edge_proc_pkg;

    localparam int c_img_cols     = 80;
    localparam int c_img_rows     = 60;
    localparam int c_nb_line_pxls = 7;
    localparam int c_nb_img_pxls  = 13;
    localparam int c_nb_gray      = 8;

    typedef logic [c_nb_line_pxls-1:0] cnt_t;
    typedef logic [c_nb_img_pxls-1:0]  addr_t;
    typedef logic [c_nb_gray-1:0]      pix_t;
    typedef pix_t [2:0][2:0]           win_t;   // [row][col], row 0 is the top line

    localparam cnt_t  c_last_col  = cnt_t'(c_img_cols);
    localparam cnt_t  c_last_row  = cnt_t'(c_img_rows);
    localparam addr_t c_cols_addr = addr_t'(c_img_cols);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SCAN,
        ST_FLUSH
    } state_t;

    typedef struct packed {
        logic valid;
        logic pad;
        cnt_t row;
        cnt_t col;
    } step_t;

    function automatic addr_t raster_addr(input cnt_t row, input cnt_t col);
        return addr_t'(row) * c_cols_addr + addr_t'(col);
    endfunction

    function automatic logic signed [10:0] widen(input pix_t p);
        return $signed({3'b000, p});
    endfunction

endpackage

// File: rtl/sobel_kernel.sv
// Sobel arithmetic: registers gx/gy (S2), then |gx|+|gy| saturated to 8 bits with write strobe (S3).
module sobel_kernel
    import sobel_edge_proc_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  win_t  win,
    input  logic  in_valid,
    input  logic  in_zero,
    input  addr_t in_addr,
    output logic  s2_valid,
    output logic  we,
    output addr_t addr,
    output pix_t  dout
);

    logic signed [10:0] gx, gy, gx_q, gy_q;
    logic               s2_zero;
    addr_t              s2_addr;
    logic [10:0]        abs_x, abs_y;
    logic [11:0]        mag;
    pix_t               sat;

    always_comb begin
        gx = (widen(win[0][2]) + (widen(win[1][2]) <<< 1) + widen(win[2][2]))
           - (widen(win[0][0]) + (widen(win[1][0]) <<< 1) + widen(win[2][0]));
        gy = (widen(win[2][0]) + (widen(win[2][1]) <<< 1) + widen(win[2][2]))
           - (widen(win[0][0]) + (widen(win[0][1]) <<< 1) + widen(win[0][2]));
        abs_x = gx_q[10] ? 11'(-gx_q) : 11'(gx_q);
        abs_y = gy_q[10] ? 11'(-gy_q) : 11'(gy_q);
        mag   = {1'b0, abs_x} + {1'b0, abs_y};
        sat   = (mag[11:8] != 4'd0) ? 8'hFF : mag[7:0];
    end

    // NOTE: sequential state uses non-blocking assignments so every stage samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gx_q     <= '0;
            gy_q     <= '0;
            s2_valid <= 1'b0;
            s2_zero  <= 1'b0;
            s2_addr  <= '0;
            we       <= 1'b0;
            addr     <= '0;
            dout     <= '0;
        end else begin
            s2_valid <= in_valid;
            if (in_valid) begin
                gx_q    <= gx;
                gy_q    <= gy;
                s2_zero <= in_zero;
                s2_addr <= in_addr;
            end
            we <= s2_valid;
            if (s2_valid) begin
                addr <= s2_addr;
                dout <= s2_zero ? '0 : sat;
            end
        end
    end

endmodule

// File: rtl/sobel_edge_proc.sv
// Frame-buffer to frame-buffer Sobel edge detector: scan FSM, line buffers and 3x3 window.
module sobel_edge_proc
    import sobel_edge_proc_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output addr_t       orig_addr,
    input  pix_t        orig_pxl,
    output addr_t       proc_addr,
    output pix_t        proc_dout,
    output logic        proc_we
);

    state_t     state;
    cnt_t       row_cnt, col_cnt;
    step_t      s0, s1;
    logic       pad_step;
    logic       kernel_busy;

    pix_t       lb1 [0:c_img_cols];
    pix_t       lb2 [0:c_img_cols];
    pix_t [2:0] col0_q, col1_q, new_col;
    win_t       win;
    logic       wr_step, border;
    addr_t      centre_addr;

    assign pad_step = (row_cnt == c_last_row) || (col_cnt == c_last_col);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            row_cnt   <= '0;
            col_cnt   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            orig_addr <= '0;
            s0        <= '0;
        end else begin
            done <= 1'b0;
            s0   <= '0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        row_cnt <= '0;
                        col_cnt <= '0;
                        busy    <= 1'b1;
                        state   <= ST_SCAN;
                    end
                end
                ST_SCAN: begin
                    s0 <= '{valid: 1'b1, pad: pad_step, row: row_cnt, col: col_cnt};
                    if (!pad_step) orig_addr <= raster_addr(row_cnt, col_cnt);
                    if (col_cnt == c_last_col) begin
                        col_cnt <= '0;
                        if (row_cnt == c_last_row) state <= ST_FLUSH;
                        else                       row_cnt <= row_cnt + 7'd1;
                    end else begin
                        col_cnt <= col_cnt + 7'd1;
                    end
                end
                ST_FLUSH: begin
                    // The final step writes, so done lands one clock after that write.
                    if (!s0.valid && !s1.valid && !kernel_busy) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // s1 lines up with the pixel the synchronous RAM returns for the s0 address.
    always_comb begin
        new_col    = '0;
        new_col[0] = lb2[s1.col];
        new_col[1] = lb1[s1.col];
        new_col[2] = s1.pad ? '0 : orig_pxl;
        win = '0;
        for (int i = 0; i < 3; i++) begin
            win[i][0] = col0_q[i];
            win[i][1] = col1_q[i];
            win[i][2] = new_col[i];
        end
        wr_step     = s1.valid && (s1.row != '0) && (s1.col != '0);
        border      = (s1.row == 7'd1) || (s1.row == c_last_row) ||
                      (s1.col == 7'd1) || (s1.col == c_last_col);
        centre_addr = raster_addr(s1.row, s1.col) - c_cols_addr - addr_t'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1     <= '0;
            col0_q <= '0;
            col1_q <= '0;
        end else begin
            s1 <= s0;
            if (s1.valid) begin
                col0_q <= col1_q;
                col1_q <= new_col;
            end
        end
    end

    // NOTE: line buffers are storage, not control state: left out of reset so they map to RAM.
    always_ff @(posedge clk) begin
        if (s1.valid) begin
            lb2[s1.col] <= lb1[s1.col];
            lb1[s1.col] <= new_col[2];
        end
    end

    sobel_kernel u_kernel (
        .clk      (clk),
        .rst      (rst),
        .win      (win),
        .in_valid (wr_step),
        .in_zero  (border),
        .in_addr  (centre_addr),
        .s2_valid (kernel_busy),
        .we       (proc_we),
        .addr     (proc_addr),
        .dout     (proc_dout)
    );

endmodule

// File: tb/tb_sobel_edge_proc.sv
// Self-checking bench for sobel_edge_proc: frame passes scored against a software Sobel model.
module tb_sobel_edge_proc;
    import sobel_edge_proc_pkg::*;

    localparam int n_pix = c_img_cols * c_img_rows;

    logic  clk = 1'b0;
    logic  rst;
    logic  start;
    logic  busy, done, proc_we;
    addr_t orig_addr, proc_addr;
    pix_t  orig_pxl, proc_dout;

    always #10 clk = ~clk;

    sobel_edge_proc dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .orig_addr (orig_addr),
        .orig_pxl  (orig_pxl),
        .proc_addr (proc_addr),
        .proc_dout (proc_dout),
        .proc_we   (proc_we)
    );

    typedef struct {
        int addr;
        int data;
    } wr_t;

    typedef struct {
        string name;
        int    kind;
        int    row;
        int    col;
        int    exp;
    } probe_t;

    logic [7:0] orig_mem [n_pix];
    logic [7:0] res_mem  [n_pix];
    int         hits     [n_pix];
    wr_t        sb[$];
    probe_t     probes[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int wr_cnt, done_cnt, first_addr, last_addr, last_wr_cyc, done_cyc;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Source frame buffer: synchronous read, data one clock after the address.
    always @(posedge clk) orig_pxl <= (int'(orig_addr) < n_pix) ? orig_mem[orig_addr] : 8'h00;

    // Write monitor and scoreboard, sampled just after the active edge.
    always @(posedge clk) begin
        wr_t e;
        #1;
        cyc++;
        if (proc_we) begin
            wr_cnt++;
            last_wr_cyc = cyc;
            if (wr_cnt == 1) first_addr = int'(proc_addr);
            last_addr = int'(proc_addr);
            if (int'(proc_addr) < n_pix) begin
                hits[proc_addr]++;
                res_mem[proc_addr] = proc_dout;
            end
            if (sb.size() == 0) begin
                check("unexpected_write", int'(proc_addr), -1);
            end else begin
                e = sb.pop_front();
                check("wr_addr", int'(proc_addr), e.addr);
                check("wr_data", int'(proc_dout), e.data);
            end
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    function automatic int px(input int r, input int c);
        return int'(orig_mem[r * c_img_cols + c]);
    endfunction

    function automatic int model_pix(input int r, input int c);
        int gx, gy, m;
        if (r == 0 || r == c_img_rows - 1 || c == 0 || c == c_img_cols - 1) return 0;
        gx = (px(r-1, c+1) + 2 * px(r, c+1) + px(r+1, c+1))
           - (px(r-1, c-1) + 2 * px(r, c-1) + px(r+1, c-1));
        gy = (px(r+1, c-1) + 2 * px(r+1, c) + px(r+1, c+1))
           - (px(r-1, c-1) + 2 * px(r-1, c) + px(r-1, c+1));
        m = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
        return (m > 255) ? 255 : m;
    endfunction

    // kind: 0 flat 0x80, 1 vertical step at col 40, 2 horizontal ramp, 3 random
    task automatic load_image(input int kind);
        for (int a = 0; a < n_pix; a++) begin
            case (kind)
                0:       orig_mem[a] = 8'h80;
                1:       orig_mem[a] = ((a % c_img_cols) >= 40) ? 8'hFF : 8'h00;
                2:       orig_mem[a] = 8'(a % c_img_cols);
                default: orig_mem[a] = 8'($urandom_range(0, 255));
            endcase
        end
    endtask

    task automatic prepare_pass(input int kind);
        load_image(kind);
        wr_cnt = 0;
        done_cnt = 0;
        first_addr = -1;
        last_addr = -1;
        last_wr_cyc = 0;
        done_cyc = 0;
        for (int a = 0; a < n_pix; a++) hits[a] = 0;
        sb.delete();
        for (int a = 0; a < n_pix; a++) sb.push_back('{addr: a, data: model_pix(a / c_img_cols, a % c_img_cols)});
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        check("done_timeout", int'(seen), 1);
    endtask

    task automatic pass_stats();
        int bad;
        bad = 0;
        for (int a = 0; a < n_pix; a++) if (hits[a] != 1) bad++;
        check("done_count", done_cnt, 1);
        check("write_count", wr_cnt, n_pix);
        check("sb_left", sb.size(), 0);
        check("addr_not_once", bad, 0);
        check("first_addr", first_addr, 0);
        check("last_addr", last_addr, n_pix - 1);
        check("done_after_last_wr", done_cyc - last_wr_cyc, 1);
        check("busy_at_done", int'(busy), 0);
    endtask

    task automatic run_pass(input int kind, input int second_start);
        prepare_pass(kind);
        pulse_start();
        check("busy_after_start", int'(busy), 1);
        if (second_start > 0) begin
            repeat (second_start - 1) @(negedge clk);
            pulse_start();
        end
        wait_done(6000);
        pass_stats();
        repeat (4) @(negedge clk);
        check("done_count_settled", done_cnt, 1);
        check("write_count_settled", wr_cnt, n_pix);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int w0;

        probes.push_back('{"flat_mid",    0, 30, 40, 0});
        probes.push_back('{"flat_corner", 0,  0,  0, 0});
        probes.push_back('{"vstep_c39",   1, 10, 39, 255});
        probes.push_back('{"vstep_c40",   1, 10, 40, 255});
        probes.push_back('{"vstep_c38",   1, 10, 38, 0});
        probes.push_back('{"vstep_c41",   1, 10, 41, 0});
        probes.push_back('{"vstep_top",   1,  0, 39, 0});
        probes.push_back('{"ramp_mid",    2,  5,  5, 8});
        probes.push_back('{"ramp_c78",    2, 40, 78, 8});
        probes.push_back('{"ramp_right",  2,  5, 79, 0});
        probes.push_back('{"ramp_left",   2,  5,  0, 0});
        probes.push_back('{"ramp_bottom", 2, 59,  5, 0});

        rst = 1'b1;
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_we", int'(proc_we), 0);
        check("rst_orig_addr", int'(orig_addr), 0);
        check("rst_proc_addr", int'(proc_addr), 0);
        check("rst_proc_dout", int'(proc_dout), 0);
        rst = 1'b0;
        @(negedge clk);

        // Flat, vertical step, and ramp with an ignored second start 100 clocks in.
        for (int kind = 0; kind < 3; kind++) begin
            run_pass(kind, (kind == 2) ? 100 : 0);
            for (int i = 0; i < probes.size(); i++)
                if (probes[i].kind == kind)
                    check(probes[i].name,
                          int'(res_mem[probes[i].row * c_img_cols + probes[i].col]), probes[i].exp);
        end

        // Random image, then a start raised in the very cycle done is high.
        prepare_pass(3);
        pulse_start();
        wait_done(6000);
        pass_stats();
        prepare_pass(3);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("busy_after_done_start", int'(busy), 1);
        wait_done(6000);
        pass_stats();
        repeat (4) @(negedge clk);

        // Reset mid-pass aborts with no done and no writes; next pass is clean.
        prepare_pass(0);
        pulse_start();
        repeat (2000) @(negedge clk);
        rst = 1'b1;
        #1;
        check("abort_busy", int'(busy), 0);
        check("abort_done", int'(done), 0);
        check("abort_we", int'(proc_we), 0);
        check("abort_orig_addr", int'(orig_addr), 0);
        check("abort_proc_addr", int'(proc_addr), 0);
        check("abort_proc_dout", int'(proc_dout), 0);
        sb.delete();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        w0 = wr_cnt;
        repeat (50) @(negedge clk);
        check("abort_no_done", done_cnt, 0);
        check("abort_no_write", wr_cnt, w0);
        check("abort_idle", int'(busy), 0);
        run_pass(0, 0);
        for (int i = 0; i < probes.size(); i++)
            if (probes[i].kind == 0)
                check({"rerun_", probes[i].name},
                      int'(res_mem[probes[i].row * c_img_cols + probes[i].col]), probes[i].exp);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
